seq_mult: RTL and testbench
===========================

Name: seq_mult

Overview:
- Parametrised sequential shift-and-add unsigned multiplier; the successor to the fixed 4x4 combinational array multiplier.
- Reuses one W-bit ripple-carry adder, built from full_adder cells, across W cycles instead of a W×W adder array.
- Uses valid/ready handshakes on both operand input and product output, so it sits between a register-based operand source and a result consumer.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands a, b present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand (unsigned)
- b  input  WIDTH  multiplier (unsigned)
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  a*b

Behaviour:
- One clock. Reset is synchronous and active-low. All state updates on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - state=IDLE, count=0, product register=0, multiplicand register=0, out_valid=0.
  - in_ready is 0 while rst_n=0 (gated combinationally).
  - Reset mid-operation aborts the operation and discards its result; nothing is emitted.
- States: IDLE, BUSY, DONE (2-bit encoding from the package).
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: mreg<=a, P<={WIDTH'0, b}, count<=0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle: {c, s} = P[2W-1:W] + (P[0] ? mreg : 0), computed by the ripple adder, (WIDTH+1)-bit result.
  - Update: P <= {c, s, P[W-1:1]}.
  - count <= count+1. When count==WIDTH-1, go to DONE.
- DONE:
  - out_valid=1; product=P, held stable while out_ready=0.
  - On out_ready=1: go to IDLE; out_valid drops on the next cycle.
- Latency:
  - Operands accepted at edge T → out_valid high after edge T+WIDTH.
  - Earliest next accept is at edge T+WIDTH+2 (DONE→IDLE costs one cycle; no combinational ready pass-through).
- Throughput: one product per WIDTH+2 cycles with out_ready tied high.
- in_valid while not in IDLE is ignored. a/b need only be stable on the accepting edge.
- product output:
  - Is the P register directly and holds its last value in IDLE.
  - Changes while in BUSY; it is meaningful only when out_valid=1.
- Arithmetic:
  - Unsigned only.
  - No overflow is possible: the full 2*WIDTH-bit result is always exact.
  - The carry c must be captured, not dropped.
  - Maximum case (2^W-1)^2 must be exact.
- count width is clog2(WIDTH)+1 bits. It must not wrap before reaching WIDTH-1.
- Zero operands take the full WIDTH cycles; there is no early termination.

Decomposition:
- Package seq_mult_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2.
  - Helper function for the count width.
- Sub-module ripple_adder:
  - Parameter WIDTH.
  - Ports: inputs x, y, cin; outputs sum, cout.
  - Generate-loop chain of the existing full_adder cells.
  - Instantiated once with cin=0. It is purely combinational and verified standalone.
- seq_mult holds the FSM, counter, and the P and mreg registers. It is about 150 lines of RTL plus about 40 for ripple_adder.

Test Plan:
- WIDTH=4, a=13, b=11, out_ready=1:
  - out_valid rises exactly 4 edges after accept.
  - product=143 (8'h8F).
  - in_ready back to 1 two cycles later.
- WIDTH=4, a=15, b=15, then a=0, b=9:
  - product=225 (8'hE1), then product=0.
  - Each takes the full 4 BUSY cycles; this carry capture check covers the maximum case.
- WIDTH=4, a=6, b=7, out_ready held 0 for 5 cycles:
  - out_valid stays 1 with product=42 stable throughout.
  - in_valid pulses during the wait are ignored.
  - On out_ready=1, exactly one transfer occurs.
- WIDTH=4, accept a=9, b=5; drive rst_n=0 on the 2nd BUSY cycle for 1 cycle:
  - out_valid=0, product=0, state IDLE, in_ready=0 during reset and 1 after.
  - No product is emitted; a new a=3, b=3 then gives 9.
- WIDTH=8, a=255, b=255, then a=200, b=3:
  - product=65025 (16'hFE01) after 8 edges, then 600.
- WIDTH=4, exhaustive 256 pairs, randomized in_valid/out_ready:
  - Every product matches a*b.
  - Handshake count in equals count out.
  - No product is emitted twice.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Provides the FSM state encoding and the counter width helper.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The iteration counter must reach WIDTH-1 without wrapping.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Ports: a, b, cin in; s (sum), cout out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder built as a chain of full_adder cells.
// Ports: x, y (WIDTH), cin in; sum (WIDTH), cout out.
module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (w_c[i]),
            .s    (sum[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout = w_c[WIDTH];

endmodule

// File: rtl/seq_mult.sv
// Sequential unsigned shift-and-add multiplier, WIDTH cycles per product.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with a, b;
//        out_valid/out_ready with product (2*WIDTH bits).
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_w(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_mreg;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_last;

    // Multiplier bits sit in the low half of P and are consumed LSB first.
    assign w_addend = r_p[0] ? r_mreg : '0;
    assign w_last   = (r_count == CW'(WIDTH - 1));

    ripple_adder #(.WIDTH(WIDTH)) u_add (
        .x    (r_p[2*WIDTH-1:WIDTH]),
        .y    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = rst_n;
                if (in_valid) w_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_p     <= '0;
            r_mreg  <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mreg  <= a;
                        r_p     <= {{WIDTH{1'b0}}, b};
                        r_count <= '0;
                    end
                end
                ST_BUSY: begin
                    // Carry becomes the new MSB; P shifts right by one.
                    r_p     <= {w_cout, w_sum, r_p[WIDTH-1:1]};
                    r_count <= r_count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign product = r_p;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult at WIDTH=4 and WIDTH=8.
// Drivers push expected products; monitors pop on each output transfer.
`timescale 1ns/1ps
module tb_seq_mult;

    logic        clk;
    logic        rst_n;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    int errors = 0;
    int checks = 0;
    int n_in4  = 0;
    int n_out4 = 0;
    int n_in8  = 0;
    int n_out8 = 0;
    bit ex_done = 0;

    seq_mult #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .product   (product4)
    );

    seq_mult #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitors: outputs and handshakes are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            n_out4++;
            if (q4.size() == 0) begin
                chk("unexpected_product4", 64'(product4), 64'hFFFF);
            end else begin
                chk("product4", 64'(product4), 64'(q4.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            n_out8++;
            if (q8.size() == 0) begin
                chk("unexpected_product8", 64'(product8), 64'hFFFFFF);
            end else begin
                chk("product8", 64'(product8), 64'(q8.pop_front()));
            end
        end
    end

    task automatic send4(input logic [3:0] ta, input logic [3:0] tb);
        int  k;
        bit  ok;
        k  = 0;
        ok = 0;
        @(posedge clk);
        #1;
        in_valid4 = 1'b1;
        a4 = ta;
        b4 = tb;
        while (!ok && k < 300) begin
            @(negedge clk);
            if (in_ready4) ok = 1;
            else k++;
        end
        if (!ok) begin
            chk("accept_timeout4", 64'(k), 64'd0);
        end else begin
            q4.push_back(8'(ta) * 8'(tb));
            n_in4++;
        end
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] ta, input logic [7:0] tb);
        int  k;
        bit  ok;
        k  = 0;
        ok = 0;
        @(posedge clk);
        #1;
        in_valid8 = 1'b1;
        a8 = ta;
        b8 = tb;
        while (!ok && k < 300) begin
            @(negedge clk);
            if (in_ready8) ok = 1;
            else k++;
        end
        if (!ok) begin
            chk("accept_timeout8", 64'(k), 64'd0);
        end else begin
            q8.push_back(16'(ta) * 16'(tb));
            n_in8++;
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
    endtask

    // Called just after the accept edge; counts edges until out_valid.
    task automatic wait_lat4(output int n);
        n = 0;
        while (!out_valid4 && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_lat8(output int n);
        n = 0;
        while (!out_valid8 && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((q4.size() != 0 || q8.size() != 0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(q4.size() + q8.size()), 64'd0);
    endtask

    initial begin
        int lat;
        int n0;
        int seen;

        rst_n      = 1'b0;
        in_valid4  = 1'b0;
        in_valid8  = 1'b0;
        out_ready4 = 1'b1;
        out_ready8 = 1'b1;
        a4 = '0;
        b4 = '0;
        a8 = '0;
        b8 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready4), 64'd0);
        chk("rst_out_valid", 64'(out_valid4), 64'd0);
        chk("rst_product", 64'(product4), 64'd0);
        chk("rst_product8", 64'(product8), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready4), 64'd1);

        // 13 * 11 with latency and ready recovery
        send4(4'd13, 4'd11);
        wait_lat4(lat);
        chk("lat_13x11", 64'(lat), 64'd4);
        chk("done_in_ready", 64'(in_ready4), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("ready_back", 64'(in_ready4), 64'd1);
        chk("valid_drop", 64'(out_valid4), 64'd0);
        drain("drain_1");

        // Maximum case and zero multiplicand
        send4(4'd15, 4'd15);
        wait_lat4(lat);
        chk("lat_15x15", 64'(lat), 64'd4);
        chk("max_value", 64'(product4), 64'd225);
        send4(4'd0, 4'd9);
        wait_lat4(lat);
        chk("lat_0x9", 64'(lat), 64'd4);
        drain("drain_2");

        // Backpressure: hold product, ignore in_valid pulses
        @(posedge clk);
        #1 out_ready4 = 1'b0;
        send4(4'd6, 4'd7);
        wait_lat4(lat);
        chk("lat_6x7", 64'(lat), 64'd4);
        n0 = n_out4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid4 = i[0];
            a4 = 4'd1;
            b4 = 4'd1;
            @(negedge clk);
            chk("hold_valid", 64'(out_valid4), 64'd1);
            chk("hold_product", 64'(product4), 64'd42);
            chk("hold_in_ready", 64'(in_ready4), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("one_transfer", 64'(n_out4 - n0), 64'd1);
        chk("after_xfer_valid", 64'(out_valid4), 64'd0);
        drain("drain_3");

        // Reset in the second BUSY cycle aborts 9 * 5
        send4(4'd9, 4'd5);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready4), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid4), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        void'(q4.pop_back());
        n_in4--;
        @(negedge clk);
        chk("post_rst_product", 64'(product4), 64'd0);
        chk("post_rst_out_valid", 64'(out_valid4), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready4), 64'd1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid4) seen++;
        end
        chk("no_emit_after_rst", 64'(seen), 64'd0);
        send4(4'd3, 4'd3);
        wait_lat4(lat);
        chk("lat_3x3", 64'(lat), 64'd4);
        drain("drain_4");

        // WIDTH=8
        send8(8'd255, 8'd255);
        wait_lat8(lat);
        chk("lat8_255", 64'(lat), 64'd8);
        chk("max_value8", 64'(product8), 64'd65025);
        send8(8'd200, 8'd3);
        wait_lat8(lat);
        chk("lat8_200x3", 64'(lat), 64'd8);
        drain("drain_5");

        // Exhaustive WIDTH=4 with random gaps and backpressure
        n0 = n_out4;
        fork
            begin
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                        send4(4'(x), 4'(y));
                    end
                end
                drain("drain_ex");
                ex_done = 1;
            end
            begin
                while (!ex_done) begin
                    @(posedge clk);
                    #1 out_ready4 = ($urandom_range(0, 3) != 0);
                end
                out_ready4 = 1'b1;
            end
        join
        chk("ex_count", 64'(n_out4 - n0), 64'd256);
        chk("in_out_count4", 64'(n_out4), 64'(n_in4));
        chk("in_out_count8", 64'(n_out8), 64'(n_in8));

        repeat (10) @(negedge clk);
        chk("final_out_valid", 64'(out_valid4), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
